// File: rtl/ascon_seq_ctrl_pkg.sv
// Shared types for the Ascon-128 sequencing controller: datapath op codes,
// FSM state encoding and default round counts.
package ascon_ctrl_pkg;

  localparam int unsigned PA_DEF = 12;
  localparam int unsigned PB_DEF = 6;

  // OP_NONE is the idle/reset encoding; it is never strobed with dp_op_vld.
  typedef enum logic [2:0] {
    OP_NONE       = 3'd0,
    OP_LOAD_INIT  = 3'd1,
    OP_KEY_TAIL   = 3'd2,
    OP_ABSORB_AD  = 3'd3,
    OP_DOM_SEP    = 3'd4,
    OP_ABSORB_TXT = 3'd5,
    OP_KEY_FINAL  = 3'd6
  } dp_op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_INIT_P,
    S_INIT_K,
    S_WAIT_AD,
    S_ABS_AD,
    S_AD_P,
    S_DSEP,
    S_WAIT_TXT,
    S_ABS_TXT,
    S_TXT_P,
    S_FIN_K,
    S_FIN_P,
    S_TAG_K,
    S_TAG,
    S_DONE
  } ctrl_state_e;

  // An n-round permutation uses the last n round constants of p^a.
  function automatic logic [3:0] first_round_idx(int unsigned pa, logic [3:0] n);
    return 4'(pa) - n;
  endfunction

endpackage

// File: rtl/ascon_seq_ctrl_if.sv
// Block/tag handshake and datapath strobe bundle between the sequencing
// controller (master) and the register front-end/datapath (slave).
interface ascon_seq_ctrl_if;
  import ascon_ctrl_pkg::*;

  logic       blk_valid;
  logic       blk_ready;
  logic       blk_is_ad;
  logic       blk_last;
  logic       tag_valid;
  logic       tag_ready;
  dp_op_e     dp_op;
  logic       dp_op_vld;
  logic       round_en;
  logic [3:0] round_idx;

  modport master (
    input  blk_valid, blk_is_ad, blk_last, tag_ready,
    output blk_ready, tag_valid, dp_op, dp_op_vld, round_en, round_idx
  );

  modport slave (
    output blk_valid, blk_is_ad, blk_last, tag_ready,
    input  blk_ready, tag_valid, dp_op, dp_op_vld, round_en, round_idx
  );

endinterface

// File: rtl/ascon_seq_ctrl_round_cnt.sv
// Permutation round sequencer: after a load pulse, runs n_rounds consecutive
// round_en cycles with round_idx stepping up to PA_ROUNDS-1.
module ascon_round_cnt
  import ascon_ctrl_pkg::*;
#(
  parameter int unsigned PA_ROUNDS = PA_DEF
) (
  input  logic       clk_in,
  input  logic       reset_int,
  input  logic       load,
  input  logic       clear,
  input  logic [3:0] n_rounds,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic       last_round
);

  localparam logic [3:0] LAST_IDX = 4'(PA_ROUNDS - 1);

  // NOTE: all state here uses non-blocking assignments so round_en/round_idx
  // are clean flops that the FSM can sample in the same edge without races.
  always_ff @(posedge clk_in) begin
    if (reset_int || clear) begin
      round_en  <= 1'b0;
      round_idx <= '0;
    end else if (load) begin
      round_en  <= 1'b1;
      round_idx <= first_round_idx(PA_ROUNDS, n_rounds);
    end else if (round_en) begin
      if (round_idx == LAST_IDX) begin
        round_en  <= 1'b0;
        round_idx <= '0;
      end else begin
        round_idx <= round_idx + 4'd1;
      end
    end
  end

  assign last_round = round_en && (round_idx == LAST_IDX);

endmodule

// File: rtl/ascon_seq_ctrl.sv
// Ascon-128 AEAD phase sequencer: meters data blocks, issues datapath op
// strobes, drives the round counter and raises done/irq on completion.
module ascon_seq_ctrl
  import ascon_ctrl_pkg::*;
#(
  parameter int unsigned PA_ROUNDS = PA_DEF,
  parameter int unsigned PB_ROUNDS = PB_DEF
) (
  input  logic              clk_in,
  input  logic              reset_int,
  input  logic              start,
  input  logic              abort,
  input  logic              irq_en,
  ascon_seq_ctrl_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              irq
);

  ctrl_state_e state;
  logic        last_q;
  logic        rc_load;
  logic [3:0]  rc_n;
  logic        last_round;

  // The counter is loaded during the one-cycle state preceding each *_P state,
  // so its first round_en cycle coincides with entry into that state.
  always_comb begin
    rc_load = 1'b0;
    rc_n    = 4'(PB_ROUNDS);
    if (!abort) begin
      case (state)
        S_LOAD, S_FIN_K: begin
          rc_load = 1'b1;
          rc_n    = 4'(PA_ROUNDS);
        end
        S_ABS_AD:  rc_load = 1'b1;
        S_ABS_TXT: rc_load = !last_q;
        default:   rc_load = 1'b0;
      endcase
    end
  end

  ascon_round_cnt #(.PA_ROUNDS(PA_ROUNDS)) u_round_cnt (
    .clk_in     (clk_in),
    .reset_int  (reset_int),
    .load       (rc_load),
    .clear      (abort),
    .n_rounds   (rc_n),
    .round_en   (bus.round_en),
    .round_idx  (bus.round_idx),
    .last_round (last_round)
  );

  always_ff @(posedge clk_in) begin
    if (reset_int) begin
      state         <= S_IDLE;
      last_q        <= 1'b0;
      bus.dp_op     <= OP_NONE;
      bus.dp_op_vld <= 1'b0;
      bus.blk_ready <= 1'b0;
      bus.tag_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      irq           <= 1'b0;
    end else begin
      bus.dp_op_vld <= 1'b0;
      done          <= 1'b0;
      irq           <= done & irq_en;
      if (abort) begin
        state         <= S_IDLE;
        bus.blk_ready <= 1'b0;
        bus.tag_valid <= 1'b0;
        busy          <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            state         <= S_LOAD;
            bus.dp_op     <= OP_LOAD_INIT;
            bus.dp_op_vld <= 1'b1;
            busy          <= 1'b1;
            err           <= 1'b0;
          end
          S_LOAD: state <= S_INIT_P;
          S_INIT_P: if (last_round) begin
            state         <= S_INIT_K;
            bus.dp_op     <= OP_KEY_TAIL;
            bus.dp_op_vld <= 1'b1;
          end
          S_INIT_K: begin
            state         <= S_WAIT_AD;
            bus.blk_ready <= 1'b1;
          end
          // A text block seen here is left pending for WAIT_TXT: the
          // front-end only treats it as taken once an absorb op follows.
          S_WAIT_AD: if (bus.blk_valid) begin
            bus.blk_ready <= 1'b0;
            bus.dp_op_vld <= 1'b1;
            if (bus.blk_is_ad) begin
              state     <= S_ABS_AD;
              bus.dp_op <= OP_ABSORB_AD;
              last_q    <= bus.blk_last;
            end else begin
              state     <= S_DSEP;
              bus.dp_op <= OP_DOM_SEP;
            end
          end
          S_ABS_AD: state <= S_AD_P;
          S_AD_P: if (last_round) begin
            if (last_q) begin
              state         <= S_DSEP;
              bus.dp_op     <= OP_DOM_SEP;
              bus.dp_op_vld <= 1'b1;
            end else begin
              state         <= S_WAIT_AD;
              bus.blk_ready <= 1'b1;
            end
          end
          S_DSEP: begin
            state         <= S_WAIT_TXT;
            bus.blk_ready <= 1'b1;
          end
          S_WAIT_TXT: if (bus.blk_valid) begin
            bus.blk_ready <= 1'b0;
            if (bus.blk_is_ad) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              state         <= S_ABS_TXT;
              bus.dp_op     <= OP_ABSORB_TXT;
              bus.dp_op_vld <= 1'b1;
              last_q        <= bus.blk_last;
            end
          end
          S_ABS_TXT: if (last_q) begin
            state         <= S_FIN_K;
            bus.dp_op     <= OP_KEY_FINAL;
            bus.dp_op_vld <= 1'b1;
          end else begin
            state <= S_TXT_P;
          end
          S_TXT_P: if (last_round) begin
            state         <= S_WAIT_TXT;
            bus.blk_ready <= 1'b1;
          end
          S_FIN_K: state <= S_FIN_P;
          S_FIN_P: if (last_round) begin
            state         <= S_TAG_K;
            bus.dp_op     <= OP_KEY_FINAL;
            bus.dp_op_vld <= 1'b1;
          end
          S_TAG_K: begin
            state         <= S_TAG;
            bus.tag_valid <= 1'b1;
          end
          S_TAG: if (bus.tag_ready) begin
            state         <= S_DONE;
            bus.tag_valid <= 1'b0;
            done          <= 1'b1;
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
